word_packer: RTL and testbench

- Parametrised sequential successor to the fixed byte-concatenation block.
- Collects NUM_IN narrow words of IN_W bits, one per valid/ready handshake, into one OUT_W-bit word.
- First accepted word occupies the most-significant slot; all unused low bits are zero padding.
- Supports early termination (partial word) and output backpressure; sits between a narrow byte source and a wide register/bus sink.

---
 rtl/word_packer_pkg.sv | 20 ++
 rtl/word_packer.sv | 106 ++++++++++
 tb/tb_word_packer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/word_packer_pkg.sv
// Shared types and sizing helpers for the word packer.
package word_packer_pkg;

  // Collecting narrow words, or presenting a finished wide word.
  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_e;

  // Number of zero pad bits below the lowest slot.
  function automatic int pad_width(input int out_w, input int in_w, input int num_in);
    return out_w - in_w * num_in;
  endfunction

  // Width needed to hold a word count from 0 up to num_in inclusive.
  function automatic int count_width(input int num_in);
    return $clog2(num_in + 1);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs NUM_IN narrow words (first word in the top slot) into one wide word,
// with early termination via in_last and valid/ready on both sides.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int NUM_IN = 2,
  parameter int OUT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_W-1:0]                 out_data,
  output logic [count_width(NUM_IN)-1:0]   out_count,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CNT_W = count_width(NUM_IN);
  localparam int PAD_W = pad_width(OUT_W, IN_W, NUM_IN);

  // Reject impossible geometries at elaboration.
  generate
    if (NUM_IN < 1) begin : g_bad_num_in
      $error("word_packer: NUM_IN must be at least 1");
    end
    if (PAD_W < 0) begin : g_bad_out_w
      $error("word_packer: OUT_W must be at least IN_W*NUM_IN");
    end
  endgenerate

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [OUT_W-1:0]   acc_q,       acc_d;
  logic [OUT_W-1:0]   out_data_q,  out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  // State, slot counter, accumulator and the registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  // Next-state: drop accepted words into their slot, close the word on the
  // last slot or on in_last, and clear everything once the sink takes it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Slot k sits k words below the top of the output word.
          for (int s = 0; s < NUM_IN; s++) begin
            if (cnt_q == CNT_W'(s)) begin
              acc_d[OUT_W-1-s*IN_W -: IN_W] = in_data;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || (cnt_q == CNT_W'(NUM_IN - 1))) begin
            state_d     = OUTPUT;
            out_data_d  = acc_d;
            out_count_d = cnt_d;
          end
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d     = COLLECT;
          cnt_d       = '0;
          acc_d       = '0;
          out_data_d  = '0;
          out_count_d = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: directed cases with literal expectations plus a
// queue-based scoreboard checked every cycle on the default configuration.
module tb_word_packer;

  localparam int IN_W   = 8;
  localparam int NUM_IN = 2;
  localparam int OUT_W  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Default configuration DUT.
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_count;
  logic        out_valid, out_ready;

  // Four-slot configuration DUT, no pad bits.
  logic [7:0]  in_data4;
  logic        in_valid4, in_last4, in_ready4;
  logic [31:0] out_data4;
  logic [2:0]  out_count4;
  logic        out_valid4, out_ready4;

  word_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  word_packer #(.IN_W(8), .NUM_IN(4), .OUT_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4), .in_ready(in_ready4),
    .out_data(out_data4), .out_count(out_count4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic [7:0] grp[$];
  exp_t       expq[$];

  function automatic logic [31:0] pack(input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = w | (32'(grp[i]) << (OUT_W - (i + 1) * IN_W));
    end
    return w;
  endfunction

  // A finished word is pending exactly when the model holds one; while it is
  // pending nothing may be accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      grp.delete();
      expq.delete();
    end else begin
      automatic bit busy = (expq.size() != 0);
      exp_t e;
      chk("m_in_ready", in_ready, !busy);
      chk("m_out_valid", out_valid, busy);
      if (busy) begin
        chk("m_out_data", out_data, expq[0].d);
        chk("m_out_count", out_count, expq[0].c);
        if (out_ready) void'(expq.pop_front());
      end else if (in_valid) begin
        grp.push_back(in_data);
        if (in_last || grp.size() == NUM_IN) begin
          e.d = pack(grp.size());
          e.c = grp.size();
          expq.push_back(e);
          grp.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d, input logic last);
    bit ok;
    int n;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    chk("send_accept", ok, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_data4 = '0; in_valid4 = 1'b0; in_last4 = 1'b0; out_ready4 = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", out_count, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Two-word packing.
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    chk("full_valid", out_valid, 1'b1);
    chk("full_data", out_data, 32'h1020_0000);
    chk("full_count", out_count, 2'd2);
    tick();
    chk("full_delivered", out_valid, 1'b0);
    chk("full_in_ready", in_ready, 1'b1);

    // Early termination on the first word.
    send(8'h10, 1'b1);
    chk("last1_data", out_data, 32'h1000_0000);
    chk("last1_count", out_count, 2'd1);
    tick();

    // Backpressure with a pending input word.
    out_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    in_data = 8'h30; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", out_data, 32'h1020_0000);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_delivered", out_valid, 1'b0);
    chk("bp_ready_again", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_data", out_data, 32'h3000_0000);
    tick();

    // Reset mid-collection discards the partial word.
    send(8'hAA, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_data", out_data, 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    chk("rstmid_after", out_data, 32'h0102_0000);
    chk("rstmid_count", out_count, 2'd2);
    tick();

    // Reset while a finished word is waiting on the sink.
    out_ready = 1'b0;
    send(8'h55, 1'b1);
    chk("rstout_pre", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstout_valid", out_valid, 1'b0);
    chk("rstout_data", out_data, 32'h0);
    chk("rstout_count", out_count, 2'd0);
    tick();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Four-slot instance, no pad bits.
    in_valid4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data4 = 8'((i + 1) * 8'h11);
      tick();
    end
    in_valid4 = 1'b0;
    chk("n4_valid", out_valid4, 1'b1);
    chk("n4_data", out_data4, 32'h1122_3344);
    chk("n4_count", out_count4, 3'd4);
    tick();
    chk("n4_delivered", out_valid4, 1'b0);

    // Random traffic: continuous offers, in_last toggling, sink first always
    // ready and then randomly stalling. Offers are held until accepted.
    for (int phase = 0; phase < 2; phase++) begin
      for (int cyc = 0; cyc < 300; cyc++) begin
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (took || !in_valid) begin
          in_valid = (phase == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          in_data  = 8'($urandom);
          in_last  = 1'($urandom);
        end else if (!in_valid) begin
          in_last = 1'($urandom);
        end
        out_ready = (phase == 0) ? 1'b1 : 1'($urandom);
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
